// File: rtl/stage_wb.sv
// ---------------------------------------------------------------------------
// stage_wb : write-back stage of the 5-stage RISC-V pipeline.
//
// Holds the MEM/WB pipeline register and selects the register-file write data:
//   - LOAD      : byte/halfword/word pulled out of DMEM_data_out by the low two
//                 address bits, sign- or zero-extended according to funct3
//   - JAL/JALR  : DMEM_data_out unchanged (stage_MEM routes the link address
//                 onto it)
//   - otherwise : EX_MEM_alu_out
// Misaligned loads (and illegal load funct3 values) are captured with the
// write enable cleared and MEM_WB_misalign set.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   EX_MEM_*                     instruction currently in MEM
//   DMEM_data_out                DMEM read word / link address, same cycle
//   MEM_WB_stall / MEM_WB_flush  hold / bubble the register (flush wins)
//   MEM_WB_valid, _reg_write_en, _rd, _wb_data, _misalign
//                                registered outputs to the register file and
//                                the forwarding unit
//   MEM_WB_retire_cnt            64-bit retired-instruction count
//
// Optional feature macro: WB_RETIRE_CNT_EN
//   defined   -> retire counter and MEM_WB_retire_cnt port are present
//   undefined -> both are absent; nothing else changes
// ---------------------------------------------------------------------------
module stage_wb #(
  parameter int REG_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      EX_MEM_valid,
  input  logic                      EX_MEM_reg_write_en,
  input  logic [REG_ADDR_WIDTH-1:0] EX_MEM_rd,
  input  logic [6:0]                EX_MEM_inst_opcode,
  input  logic [2:0]                EX_MEM_funct3,
  input  logic [REG_WIDTH-1:0]      EX_MEM_alu_out,
  input  logic [REG_WIDTH-1:0]      DMEM_data_out,
  input  logic                      MEM_WB_stall,
  input  logic                      MEM_WB_flush,
  output logic                      MEM_WB_valid,
  output logic                      MEM_WB_reg_write_en,
  output logic [REG_ADDR_WIDTH-1:0] MEM_WB_rd,
  output logic [REG_WIDTH-1:0]      MEM_WB_wb_data,
  output logic                      MEM_WB_misalign
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]               MEM_WB_retire_cnt
`endif
);

  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic [1:0]           w_off;
  logic [7:0]           w_byte;
  logic [15:0]          w_half;
  logic [REG_WIDTH-1:0] w_wb_data;
  logic                 w_misalign;
  logic                 w_capture;

  logic                      r_valid;
  logic                      r_reg_write_en;
  logic [REG_ADDR_WIDTH-1:0] r_rd;
  logic [REG_WIDTH-1:0]      r_wb_data;
  logic                      r_misalign;

  assign w_off     = EX_MEM_alu_out[1:0];
  assign w_capture = !MEM_WB_flush && !MEM_WB_stall;

  // Byte and halfword lanes of the loaded word selected by the address offset.
  always_comb begin
    w_byte = 8'h00;
    case (w_off)
      2'd0:    w_byte = DMEM_data_out[7:0];
      2'd1:    w_byte = DMEM_data_out[15:8];
      2'd2:    w_byte = DMEM_data_out[23:16];
      default: w_byte = DMEM_data_out[31:24];
    endcase
  end

  assign w_half = w_off[1] ? DMEM_data_out[31:16] : DMEM_data_out[15:0];

  // Write-back data selection and misalignment detection. Misaligned
  // halfword/word loads still produce extracted data; only the write enable
  // is suppressed. Illegal load funct3 values produce zero data.
  always_comb begin
    w_wb_data  = EX_MEM_alu_out;
    w_misalign = 1'b0;
    if (EX_MEM_inst_opcode == OP_LOAD) begin
      case (EX_MEM_funct3)
        F3_LB:  w_wb_data = {{(REG_WIDTH-8){w_byte[7]}}, w_byte};
        F3_LBU: w_wb_data = {{(REG_WIDTH-8){1'b0}}, w_byte};
        F3_LH: begin
          w_wb_data  = {{(REG_WIDTH-16){w_half[15]}}, w_half};
          w_misalign = w_off[0];
        end
        F3_LHU: begin
          w_wb_data  = {{(REG_WIDTH-16){1'b0}}, w_half};
          w_misalign = w_off[0];
        end
        F3_LW: begin
          w_wb_data  = DMEM_data_out;
          w_misalign = (w_off != 2'd0);
        end
        default: begin
          w_wb_data  = '0;
          w_misalign = 1'b1;
        end
      endcase
    end else if (EX_MEM_inst_opcode == OP_JAL || EX_MEM_inst_opcode == OP_JALR) begin
      w_wb_data = DMEM_data_out;
    end
  end

  // MEM/WB register: flush beats stall beats capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid        <= 1'b0;
      r_reg_write_en <= 1'b0;
      r_rd           <= '0;
      r_wb_data      <= '0;
      r_misalign     <= 1'b0;
    end else if (MEM_WB_flush) begin
      r_valid        <= 1'b0;
      r_reg_write_en <= 1'b0;
      r_rd           <= '0;
      r_wb_data      <= '0;
      r_misalign     <= 1'b0;
    end else if (!MEM_WB_stall) begin
      r_valid        <= EX_MEM_valid;
      // Writes to x0 and misaligned loads never reach the register file.
      r_reg_write_en <= EX_MEM_valid && EX_MEM_reg_write_en &&
                        (EX_MEM_rd != '0) && !w_misalign;
      r_rd           <= EX_MEM_rd;
      r_wb_data      <= w_wb_data;
      r_misalign     <= EX_MEM_valid && w_misalign;
    end
  end

  assign MEM_WB_valid        = r_valid;
  assign MEM_WB_reg_write_en = r_reg_write_en;
  assign MEM_WB_rd           = r_rd;
  assign MEM_WB_wb_data      = r_wb_data;
  assign MEM_WB_misalign     = r_misalign;

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] r_retire_cnt;

  // Counts every real instruction at the edge it enters WB; misaligned loads
  // included. Wraps naturally at 2^64.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_retire_cnt <= '0;
    end else if (w_capture && EX_MEM_valid) begin
      r_retire_cnt <= r_retire_cnt + 64'd1;
    end
  end

  assign MEM_WB_retire_cnt = r_retire_cnt;
`else
  logic w_unused_capture;
  assign w_unused_capture = w_capture;
`endif

endmodule

// File: doc/stage_wb.md
# stage_WB

Write-back stage of the RISC-V 5-stage pipeline. Holds the MEM/WB pipeline register and selects the register-file write-back value from the ALU result, the link address, or the loaded DMEM word. Loaded words are aligned and extended per the load `funct3`. Sits directly downstream of `stage_MEM`, consumes its `DMEM_data_out`, and drives the register-file write port and the forwarding unit.

## Interface
Parameters:
- `REG_WIDTH`, `` `REG_WIDTH `` (32): datapath width.
- `REG_ADDR_WIDTH`, 5: register index width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous reset, active low.
- `EX_MEM_valid`  in  1  instruction in MEM is real (not a bubble).
- `EX_MEM_reg_write_en`  in  1  instruction writes `rd`.
- `EX_MEM_rd`  in  `REG_ADDR_WIDTH`  destination register.
- `EX_MEM_inst_opcode`  in  7  opcode.
- `EX_MEM_funct3`  in  3  load size and sign selector.
- `EX_MEM_alu_out`  in  `REG_WIDTH`  ALU result / load address.
- `DMEM_data_out`  in  `REG_WIDTH`  output of `stage_MEM`: the DMEM word, or the link address for JAL/JALR.
- `MEM_WB_stall`  in  1  hold the MEM/WB register.
- `MEM_WB_flush`  in  1  insert a bubble.
- `MEM_WB_valid`  out  1  registered valid.
- `MEM_WB_reg_write_en`  out  1  register-file write enable.
- `MEM_WB_rd`  out  `REG_ADDR_WIDTH`  register-file write index.
- `MEM_WB_wb_data`  out  `REG_WIDTH`  register-file write data.
- `MEM_WB_misalign`  out  1  the instruction in WB was a misaligned load.
- `MEM_WB_retire_cnt`  out  64  retired-instruction count. Present only with `WB_RETIRE_CNT_EN`.

## Operation
- Write-back data selection, computed combinationally from EX_MEM inputs:
  - Opcode LOAD (`7'b0000011`): extract from `DMEM_data_out` using byte offset `off = EX_MEM_alu_out[1:0]`.
    - LB (000): sign-extend byte `off`.
    - LBU (100): zero-extend byte `off`.
    - LH (001): sign-extend halfword `off[1]`.
    - LHU (101): zero-extend halfword `off[1]`.
    - LW (010): full word.
    - Other `funct3` values: zero data, treated as misaligned.
  - Opcode `` `JAL `` / `` `JALR ``: `DMEM_data_out` unchanged (link address).
  - All other opcodes: `EX_MEM_alu_out`.
- Misalignment:
  - LH/LHU with `off[0]=1`, LW with `off!=0`, or an illegal load `funct3` is misaligned.
  - A misaligned load captures write enable 0 and `misalign` 1.
- Writes to x0: captured write enable is 0 whenever `EX_MEM_rd==0`.
- Update on each rising edge, in priority order:
  1. `MEM_WB_flush=1`: valid, write enable and misalign become 0. `rd` and data become 0.
  2. Else `MEM_WB_stall=1`: all registers hold.
  3. Else capture. Valid = `EX_MEM_valid`. Write enable = `EX_MEM_valid & EX_MEM_reg_write_en & rd!=0 & !misalign`. Misalign = `EX_MEM_valid & misalign`.
- Bubble inputs (`EX_MEM_valid=0`) capture with write enable 0. Data and `rd` are still captured but must not be relied on.

## Timing
- Latency: 1 cycle from EX_MEM inputs to MEM_WB outputs. All outputs come directly from flops.
- Reset: all outputs are 0, including the retire counter. Assertion clears them immediately regardless of clock. The first capture is on the first rising edge after deassertion.
- Reset during a stall: the held contents are lost and the outputs read 0.
- Flush and stall in the same cycle: flush wins.
- `DMEM_data_out` must be valid in the same cycle as the EX_MEM inputs it belongs to, because DMEM is read combinationally.

## Configuration
- `WB_RETIRE_CNT_EN` defined:
  - 64-bit counter increments by 1 on each edge where a capture occurs with `EX_MEM_valid=1`. Misaligned loads count.
  - Flushed or stalled cycles do not count.
  - The counter wraps from 2^64-1 to 0. It is exposed on `MEM_WB_retire_cnt`.
- `WB_RETIRE_CNT_EN` undefined: the counter and its port are absent, and no other behaviour changes.

## Test plan
- LB, `DMEM_data_out=32'h80FF_7F01`, `alu_out=…02`, `rd=5` -> next cycle `wb_data=32'hFFFF_FFFF`, `reg_write_en=1`, `rd=5`. The same word with LBU and `alu_out=…03` -> `32'h0000_0080`.
- LH at `alu_out=…02` with word `32'h8001_1234` -> `32'hFFFF_8001`. LW at `alu_out=…01` -> `misalign=1`, `reg_write_en=0`.
- JAL with `DMEM_data_out=32'h0000_0104`, `rd=1` -> `wb_data=32'h104`. ADD with `alu_out=32'h55`, `rd=0` -> `reg_write_en=0`.
- Capture an ADD, then assert stall for 3 cycles while the inputs change -> outputs hold the ADD values. Assert stall and flush together -> next cycle valid=0 and write enable=0.
- With `WB_RETIRE_CNT_EN`: 10 valid instructions, 2 of them stalled once and 1 flushed -> count=9 (the stalled instructions count once, when captured). Assert `reset_n=0` mid-sequence -> count and all outputs are 0 without waiting for a clock edge.
